// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, produces every datapath
// strobe and mux select, and abandons stuck memory accesses with a watchdog.
module multicycle_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] resultsrc,
    output logic       illegal,
    output logic       memfault,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Last count value before the watchdog fires.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       wait_state;
    logic       expire;

    assign state = state_q;

    // Moore decode of the state plus the few input-dependent strobes, next-state
    // selection, and the watchdog override.
    always_comb begin
        pcwrite    = 1'b0;
        adrsrc     = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        resultsrc  = 2'b00;
        illegal    = 1'b0;
        memfault   = 1'b0;
        state_d    = S_FETCH;

        wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);
        expire     = wait_state && !mem_ready && (wait_cnt_q == WAIT_LAST);

        case (state_q)
            S_FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                memread = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                // All I-type ALU ops run as addi.
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                pcwrite = zero;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target from DECODE); ALU computes oldPC+4 for rd.
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase

        // A stuck access is abandoned: no architectural state changes, and
        // the PC is left alone so the fetch is simply retried.
        if (expire) begin
            state_d  = S_FETCH;
            memfault = 1'b1;
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end

        // Counter runs only while stalled in the same wait state.
        if (wait_state && !mem_ready && !expire && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = 8'd0;
        end

        if (rst) begin
            pcwrite   = 1'b0;
            adrsrc    = 1'b0;
            memread   = 1'b0;
            memwrite  = 1'b0;
            irwrite   = 1'b0;
            regwrite  = 1'b0;
            alusrca   = 2'b00;
            alusrcb   = 2'b00;
            aluop     = 2'b00;
            resultsrc = 2'b00;
            illegal   = 1'b0;
            memfault  = 1'b0;
        end
    end

    // State and watchdog counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one expected state/strobe record
// is queued per cycle and checked against the DUT mid-cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite, adrsrc, memread, memwrite, irwrite, regwrite;
    logic [1:0] alusrca, alusrcb, aluop, resultsrc;
    logic       illegal, memfault;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;
    int step_no = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb_q[$];

    // {pcwrite,adrsrc,memread,memwrite,irwrite,regwrite,alusrca,alusrcb,aluop,resultsrc,illegal,memfault}
    localparam logic [15:0] C_ZERO      = 16'b0_0_0_0_0_0_00_00_00_00_0_0;
    localparam logic [15:0] C_FETCH_RDY = 16'b1_0_1_0_1_0_00_10_00_10_0_0;
    localparam logic [15:0] C_FETCH_WT  = 16'b0_0_1_0_0_0_00_10_00_10_0_0;
    localparam logic [15:0] C_FETCH_FLT = 16'b0_0_1_0_0_0_00_10_00_10_0_1;
    localparam logic [15:0] C_DECODE    = 16'b0_0_0_0_0_0_01_01_00_00_0_0;
    localparam logic [15:0] C_DEC_ILL   = 16'b0_0_0_0_0_0_01_01_00_00_1_0;
    localparam logic [15:0] C_MEMADR    = 16'b0_0_0_0_0_0_10_01_00_00_0_0;
    localparam logic [15:0] C_MEMREAD   = 16'b0_1_1_0_0_0_00_00_00_00_0_0;
    localparam logic [15:0] C_MEMWB     = 16'b0_0_0_0_0_1_00_00_00_01_0_0;
    localparam logic [15:0] C_MEMWRITE  = 16'b0_1_0_1_0_0_00_00_00_00_0_0;
    localparam logic [15:0] C_MEMWR_FLT = 16'b0_1_0_0_0_0_00_00_00_00_0_1;
    localparam logic [15:0] C_EXECR     = 16'b0_0_0_0_0_0_10_00_10_00_0_0;
    localparam logic [15:0] C_EXECI     = 16'b0_0_0_0_0_0_10_01_00_00_0_0;
    localparam logic [15:0] C_ALUWB     = 16'b0_0_0_0_0_1_00_00_00_00_0_0;
    localparam logic [15:0] C_BEQ_Z     = 16'b1_0_0_0_0_0_10_00_01_00_0_0;
    localparam logic [15:0] C_BEQ_NZ    = 16'b0_0_0_0_0_0_10_00_01_00_0_0;
    localparam logic [15:0] C_JAL       = 16'b1_0_0_0_0_0_01_10_00_00_0_0;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic [15:0] ctrl_obs;
    assign ctrl_obs = {pcwrite, adrsrc, memread, memwrite, irwrite, regwrite,
                       alusrca, alusrcb, aluop, resultsrc, illegal, memfault};

    multicycle_controller #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcwrite   (pcwrite),
        .adrsrc    (adrsrc),
        .memread   (memread),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .resultsrc (resultsrc),
        .illegal   (illegal),
        .memfault  (memfault),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Queue the expectation for the current cycle, check it on the falling
    // edge, then advance past the next rising edge.
    task automatic cycle(input string tag, input logic [3:0] st, input logic [15:0] ctrl);
        exp_t e;
        e.st   = st;
        e.ctrl = ctrl;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        step_no++;
        $display("[TB] step %0d %s: state=%0d ctrl=%b (exp state=%0d ctrl=%b)",
                 step_no, tag, state, ctrl_obs, e.st, e.ctrl);
        tests++;
        assert (state === e.st) else begin
            fails++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, e.st);
        end
        tests++;
        assert (ctrl_obs === e.ctrl) else begin
            fails++;
            $error("FAIL %s ctrl: got %b expected %b", tag, ctrl_obs, e.ctrl);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Reset held: outputs all quiet, state FETCH.
        cycle("reset0", 4'd0, C_ZERO);
        cycle("reset1", 4'd0, C_ZERO);
        rst = 1'b0;

        // R-type
        cycle("r_fetch",  4'd0, C_FETCH_RDY);
        cycle("r_decode", 4'd1, C_DECODE);
        cycle("r_execr",  4'd6, C_EXECR);
        cycle("r_aluwb",  4'd8, C_ALUWB);

        // lw with two MEMREAD wait cycles
        opcode = OP_LW;
        cycle("lw_fetch",  4'd0, C_FETCH_RDY);
        cycle("lw_decode", 4'd1, C_DECODE);
        cycle("lw_memadr", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        cycle("lw_memrd0", 4'd3, C_MEMREAD);
        cycle("lw_memrd1", 4'd3, C_MEMREAD);
        mem_ready = 1'b1;
        cycle("lw_memrd2", 4'd3, C_MEMREAD);
        cycle("lw_memwb",  4'd4, C_MEMWB);

        // sw, zero wait
        opcode = OP_SW;
        cycle("sw_fetch",  4'd0, C_FETCH_RDY);
        cycle("sw_decode", 4'd1, C_DECODE);
        cycle("sw_memadr", 4'd2, C_MEMADR);
        cycle("sw_memwr",  4'd5, C_MEMWRITE);

        // beq taken then not taken
        opcode = OP_BEQ;
        zero   = 1'b1;
        cycle("beqz_fetch",  4'd0, C_FETCH_RDY);
        cycle("beqz_decode", 4'd1, C_DECODE);
        cycle("beqz_beq",    4'd9, C_BEQ_Z);
        zero   = 1'b0;
        cycle("beqn_fetch",  4'd0, C_FETCH_RDY);
        cycle("beqn_decode", 4'd1, C_DECODE);
        cycle("beqn_beq",    4'd9, C_BEQ_NZ);

        // I-type
        opcode = OP_I;
        cycle("i_fetch",  4'd0, C_FETCH_RDY);
        cycle("i_decode", 4'd1, C_DECODE);
        cycle("i_execi",  4'd7, C_EXECI);
        cycle("i_aluwb",  4'd8, C_ALUWB);

        // jal
        opcode = OP_JAL;
        cycle("jal_fetch",  4'd0, C_FETCH_RDY);
        cycle("jal_decode", 4'd1, C_DECODE);
        cycle("jal_jal",    4'd10, C_JAL);
        cycle("jal_aluwb",  4'd8, C_ALUWB);

        // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
        opcode = OP_BAD;
        cycle("ill_fetch",  4'd0, C_FETCH_RDY);
        cycle("ill_decode", 4'd1, C_DEC_ILL);

        // Watchdog in FETCH: fault on the 4th stalled cycle, retry
        opcode    = OP_R;
        mem_ready = 1'b0;
        cycle("wd_fetch1", 4'd0, C_FETCH_WT);
        cycle("wd_fetch2", 4'd0, C_FETCH_WT);
        cycle("wd_fetch3", 4'd0, C_FETCH_WT);
        cycle("wd_fetch4", 4'd0, C_FETCH_FLT);
        // Retry: ready arrives exactly at the expiry cycle, so no fault
        cycle("wd_retry1", 4'd0, C_FETCH_WT);
        cycle("wd_retry2", 4'd0, C_FETCH_WT);
        cycle("wd_retry3", 4'd0, C_FETCH_WT);
        mem_ready = 1'b1;
        cycle("wd_retry4", 4'd0, C_FETCH_RDY);
        cycle("wd_decode", 4'd1, C_DECODE);
        // Reset mid-instruction in EXECR aborts it
        rst = 1'b1;
        cycle("abort_execr", 4'd6, C_ZERO);
        cycle("abort_rst",   4'd0, C_ZERO);
        rst = 1'b0;

        // sw with MEMWRITE watchdog expiry: memwrite suppressed on the fault
        opcode = OP_SW;
        cycle("swf_fetch",  4'd0, C_FETCH_RDY);
        cycle("swf_decode", 4'd1, C_DECODE);
        cycle("swf_memadr", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        cycle("swf_wait1", 4'd5, C_MEMWRITE);
        cycle("swf_wait2", 4'd5, C_MEMWRITE);
        cycle("swf_wait3", 4'd5, C_MEMWRITE);
        cycle("swf_fault", 4'd5, C_MEMWR_FLT);
        mem_ready = 1'b1;
        cycle("swf_refetch", 4'd0, C_FETCH_RDY);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
